// File: rtl/rv32i_lsu_if.sv
// Memory-bus bundle between the RV32I load/store unit (master) and data memory (slave).
interface rv32i_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  // Handshake: req stays high from the cycle after acceptance until a cycle
  // with ack high; that rising edge completes the access and rdata is sampled then.
  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: IDLE/REQ/DONE bus sequencer with lane steering and load extension.
// Optional macro LSU_MISALIGN_CHECK_EN turns misaligned halfword/word accesses into a bus-less trap cycle.
module rv32i_lsu (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_read_en,
  input  logic        i_mem_write_en,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_be,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  state_e      state_q;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;

  logic        new_req;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign new_req = (state_q == S_IDLE) && (i_mem_read_en || i_mem_write_en);
  assign o_stall = new_req || (state_q == S_REQ);

  // Write wins when both enables are set; loads always fetch the full word.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = i_wdata;
    if (i_mem_write_en) begin
      case (i_funct3)
        3'b000: begin
          be_d    = 4'b0001 << i_addr[1:0];
          wdata_d = {4{i_wdata[7:0]}};
        end
        3'b001: begin
          be_d    = 4'b0011 << {i_addr[1], 1'b0};
          wdata_d = {2{i_wdata[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = i_wdata;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = 8'h00;
    case (lane_q)
      2'd0: ld_byte = i_bus_rdata[7:0];
      2'd1: ld_byte = i_bus_rdata[15:8];
      2'd2: ld_byte = i_bus_rdata[23:16];
      default: ld_byte = i_bus_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    case (f3_q)
      3'b000:  load_d = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_d = {24'h000000, ld_byte};
      3'b001:  load_d = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_d = {16'h0000, ld_half};
      default: load_d = i_bus_rdata;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic mis_q;
  logic acc_byte, acc_half, mis_d;

  // Store funct3 101 is a word store, so size decode depends on direction.
  always_comb begin
    if (i_mem_write_en) begin
      acc_byte = (i_funct3 == 3'b000);
      acc_half = (i_funct3 == 3'b001);
    end else begin
      acc_byte = (i_funct3 == 3'b000) || (i_funct3 == 3'b100);
      acc_half = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
    end
    mis_d = (acc_half && i_addr[0]) ||
            (!acc_byte && !acc_half && (i_addr[1:0] != 2'b00));
  end

  assign o_misaligned = mis_q;
`else
  logic mis_d;
  assign mis_d        = 1'b0;
  assign o_misaligned = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      f3_q    <= 3'b000;
      lane_q  <= 2'b00;
`ifdef LSU_MISALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (new_req) begin
            if (mis_d) begin
              state_q <= S_DONE;
`ifdef LSU_MISALIGN_CHECK_EN
              mis_q   <= 1'b1;
`endif
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
              we_q    <= i_mem_write_en;
              addr_q  <= {i_addr[31:2], 2'b00};
              wdata_q <= wdata_d;
              be_q    <= be_d;
              f3_q    <= i_funct3;
              lane_q  <= i_addr[1:0];
            end
          end
        end
        S_REQ: begin
          if (i_bus_ack) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            if (!we_q) rdata_q <= load_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
`ifdef LSU_MISALIGN_CHECK_EN
          mis_q   <= 1'b0;
`endif
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_rdata     = rdata_q;
  assign o_bus_req   = req_q;
  assign o_bus_we    = we_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_wdata = wdata_q;
  assign o_bus_be    = be_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed bench for rv32i_lsu: loads, stores, wait states, reset abort and misalignment handling.
module tb_rv32i_lsu;

  logic        clk;
  logic        rst_n;
  logic        rd_en, wr_en;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic [31:0] o_rdata;
  logic        o_stall, o_mis;

  rv32i_lsu_if bus_if ();

  rv32i_lsu dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_mem_read_en  (rd_en),
    .i_mem_write_en (wr_en),
    .i_funct3       (f3),
    .i_addr         (addr),
    .i_wdata        (wdata),
    .o_rdata        (o_rdata),
    .o_stall        (o_stall),
    .o_misaligned   (o_mis),
    .o_bus_req      (bus_if.req),
    .o_bus_we       (bus_if.we),
    .o_bus_addr     (bus_if.addr),
    .o_bus_wdata    (bus_if.wdata),
    .o_bus_be       (bus_if.be),
    .i_bus_ack      (bus_if.ack),
    .i_bus_rdata    (bus_if.rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int          tx_stalls, tx_nreq;
  logic        tx_done, tx_we, tx_mis, tx_mis_after;
  logic [31:0] tx_addr, tx_wdata, tx_rdata;
  logic [3:0]  tx_be;

  // Called at posedge+1 with the unit idle; drives one access and plays the memory side.
  task automatic run_tx(input logic rd, input logic wr, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] mem_word);
    int w;
    w = 0;
    rd_en = rd; wr_en = wr; f3 = fn; addr = a; wdata = wd;
    tx_stalls = 0; tx_nreq = 0; tx_done = 1'b0; tx_we = 1'b0; tx_mis = 1'b0;
    tx_addr = 32'h0; tx_wdata = 32'h0; tx_rdata = 32'h0; tx_be = 4'h0;
    #1;
    if (o_stall) tx_stalls++;
    if (bus_if.req) tx_nreq++;
    for (int c = 0; c < 30 && !tx_done; c++) begin
      @(posedge clk); #1;
      bus_if.ack = 1'b0;
      if (!o_stall) begin
        tx_done  = 1'b1;
        tx_rdata = o_rdata;
        tx_mis   = o_mis;
        rd_en = 1'b0; wr_en = 1'b0;
      end else begin
        tx_stalls++;
        if (bus_if.req) begin
          tx_nreq++;
          tx_addr = bus_if.addr; tx_be = bus_if.be;
          tx_wdata = bus_if.wdata; tx_we = bus_if.we;
          if (w == waits) begin
            bus_if.ack   = 1'b1;
            bus_if.rdata = mem_word;
          end else begin
            w++;
          end
        end
      end
    end
    rd_en = 1'b0; wr_en = 1'b0; bus_if.ack = 1'b0;
    @(posedge clk); #1;
    tx_mis_after = o_mis;
  endtask

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; f3 = 3'b000;
    addr = 32'h0; wdata = 32'h0;
    bus_if.ack = 1'b0; bus_if.rdata = 32'h0;
    #1;
    check("rst_rdata", o_rdata, 32'h0);
    check("rst_req",   {31'h0, bus_if.req}, 32'h0);
    check("rst_addr",  bus_if.addr, 32'h0);
    check("rst_be",    {28'h0, bus_if.be}, 32'h0);
    check("rst_stall", {31'h0, o_stall}, 32'h0);
    check("rst_mis",   {31'h0, o_mis}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_tx(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    check("lw_done",   {31'h0, tx_done}, 32'h1);
    check("lw_addr",   tx_addr, 32'h100);
    check("lw_be",     {28'h0, tx_be}, 32'hF);
    check("lw_we",     {31'h0, tx_we}, 32'h0);
    check("lw_stalls", tx_stalls, 32'd2);
    check("lw_rdata",  tx_rdata, 32'hDEADBEEF);

    run_tx(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80112233);
    check("lb_rdata",  tx_rdata, 32'hFFFFFF80);
    run_tx(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80112233);
    check("lbu_rdata", tx_rdata, 32'h00000080);
    run_tx(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80017FFF);
    check("lh_rdata",  tx_rdata, 32'hFFFF8001);
    check("lh_stalls", tx_stalls, 32'd3);
    run_tx(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 0, 32'h8001F00D);
    check("lhu_rdata", tx_rdata, 32'h0000F00D);

    run_tx(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 3, 32'h0);
    check("sh_addr",   tx_addr, 32'h200);
    check("sh_be",     {28'h0, tx_be}, 32'hC);
    check("sh_wdata",  tx_wdata, 32'hABCDABCD);
    check("sh_we",     {31'h0, tx_we}, 32'h1);
    check("sh_stalls", tx_stalls, 32'd5);
    check("sh_rdata_hold", tx_rdata, 32'h0000F00D);

    run_tx(1'b1, 1'b1, 3'b000, 32'h1, 32'h0000005A, 0, 32'h0);
    check("sb_addr",  tx_addr, 32'h0);
    check("sb_be",    {28'h0, tx_be}, 32'h2);
    check("sb_wdata", tx_wdata, 32'h5A5A5A5A);
    check("sb_we",    {31'h0, tx_we}, 32'h1);

    run_tx(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_nreq",   tx_nreq, 32'd0);
    check("mis_stalls", tx_stalls, 32'd1);
    check("mis_flag",   {31'h0, tx_mis}, 32'h1);
    check("mis_after",  {31'h0, tx_mis_after}, 32'h0);
    check("mis_rdata_hold", tx_rdata, 32'h0000F00D);
`else
    check("unal_nreq",   tx_nreq, 32'd1);
    check("unal_addr",   tx_addr, 32'h100);
    check("unal_stalls", tx_stalls, 32'd2);
    check("unal_mis",    {31'h0, tx_mis}, 32'h0);
    check("unal_rdata",  tx_rdata, 32'hCAFEF00D);
`endif

    // Abort a load mid-REQ with an asynchronous reset, then offer a stray ack.
    rd_en = 1'b1; f3 = 3'b010; addr = 32'h300;
    @(posedge clk); #1;
    rd_en = 1'b0;
    check("abort_req_up", {31'h0, bus_if.req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_req",   {31'h0, bus_if.req}, 32'h0);
    check("abort_addr",  bus_if.addr, 32'h0);
    check("abort_be",    {28'h0, bus_if.be}, 32'h0);
    check("abort_rdata", o_rdata, 32'h0);
    check("abort_stall", {31'h0, o_stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.ack = 1'b1; bus_if.rdata = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("stray_rdata", o_rdata, 32'h0);
      check("stray_req",   {31'h0, bus_if.req}, 32'h0);
      check("stray_stall", {31'h0, o_stall}, 32'h0);
      check("stray_mis",   {31'h0, o_mis}, 32'h0);
    end
    bus_if.ack = 1'b0;

    // Request presented right at reset release must be taken on the first edge.
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    run_tx(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 0, 32'h13579BDF);
    check("post_rst_stalls", tx_stalls, 32'd2);
    check("post_rst_addr",   tx_addr, 32'h404);
    check("post_rst_rdata",  tx_rdata, 32'h13579BDF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_lsu.md
RV32I_LSU -- requirements
Module: rv32i_lsu

Interface
REQ-001 The block SHALL provide these ports, in this order:
- i_clk  in  1  single clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_mem_read_en  in  1  load request from the MEM stage.
- i_mem_write_en  in  1  store request from the MEM stage.
- i_funct3  in  3  access size/sign.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data, with the valid bytes in the low bits.
- o_rdata  out  32  extended load data.
- o_stall  out  1  pipeline hold.
- o_misaligned  out  1  misaligned-access flag.
- o_bus_req  out  1  memory request.
- o_bus_we  out  1  1 = write.
- o_bus_addr  out  32  word address, bits [1:0] = 0.
- o_bus_wdata  out  32  lane-replicated store data.
- o_bus_be  out  4  byte enables.
- i_bus_ack  in  1  memory completion.
- i_bus_rdata  in  32  memory read word, valid when i_bus_ack = 1.

Function
REQ-002 The FSM SHALL have three states:
- IDLE to REQ on a new request.
- REQ to DONE on i_bus_ack.
- DONE to IDLE unconditionally.
REQ-003 A new request SHALL be i_mem_read_en or i_mem_write_en high while in IDLE; requests in REQ/DONE SHALL be ignored.
REQ-004 If both enables are high, the request SHALL be treated as a write.
REQ-005 On acceptance, the block SHALL register addr, we, be and wdata; o_bus_* SHALL drive these registered values only.
REQ-006 o_bus_req SHALL be 1 exactly while in REQ and SHALL hold until an i_bus_ack cycle; that edge moves the FSM to DONE.
REQ-007 i_bus_ack outside REQ SHALL be ignored.
REQ-008 o_stall SHALL be combinational: 1 in IDLE with a new request, 1 in REQ, 0 in DONE and 0 otherwise.
REQ-009 Minimum latency: request in cycle N -> o_bus_req in N+1 -> ack in N+1 -> DONE with o_stall = 0 in N+2.
REQ-010 Each wait cycle without ack SHALL add exactly one stall cycle.
REQ-011 The block SHALL capture i_bus_rdata on the ack edge, then lane-select and extend it.
REQ-012 o_rdata SHALL be valid throughout DONE and SHALL hold until the next load completes.
REQ-013 Load funct3 SHALL decode as:
- 000 LB: sign-extend byte at addr[1:0].
- 001 LH: sign-extend halfword at addr[1].
- 100 LBU: zero-extend byte.
- 101 LHU: zero-extend halfword.
- 010 and all other codes: full word.
REQ-014 Store funct3 SHALL decode as:
- 000 SB: be = 4'b0001 << addr[1:0]; wdata = byte replicated x4.
- 001 SH: be = 4'b0011 << (2*addr[1]); wdata = halfword replicated x2.
- other codes: SW, be = 4'b1111.
REQ-015 For reads, o_bus_be SHALL be 4'b1111.
REQ-016 o_bus_addr SHALL be {i_addr[31:2], 2'b00}.

Reset
REQ-017 Asserting i_rst_n low SHALL immediately force the following, regardless of state, including mid-transaction:
- state = IDLE
- o_bus_req = 0, o_bus_we = 0
- o_bus_addr = 0, o_bus_wdata = 0, o_bus_be = 0
- o_rdata = 0, o_misaligned = 0
REQ-018 After reset release, the first rising edge SHALL be able to accept a request.
REQ-019 An ack for an access aborted by reset SHALL be ignored.

Configuration
REQ-020 Macro LSU_MISALIGN_CHECK_EN SHALL control misalignment checking.
REQ-021 Defined: a halfword with addr[0] = 1, or a word with addr[1:0] != 0, SHALL cause the following:
- No bus request is issued.
- The FSM goes IDLE -> DONE.
- o_misaligned = 1 for that DONE cycle only.
- o_rdata holds its previous value.
- Stall is 1 cycle.
REQ-022 Not defined: low address bits not used for lane selection SHALL be ignored; the access proceeds normally, and o_misaligned SHALL be tied 0.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- LW, addr 0x100, ack in first REQ cycle, rdata 0xDEADBEEF -> o_bus_addr = 0x100, o_bus_be = 1111, o_stall 1 for 2 cycles, o_rdata = 0xDEADBEEF.
- LB, addr 0x103, rdata 0x80112233 -> o_rdata = 0xFFFFFF80; LBU, same address and data -> 0x00000080.
- SH, addr 0x202, wdata 0x0000ABCD, ack after 3 wait cycles -> be = 1100, bus wdata = 0xABCDABCD, we = 1, o_stall 1 for 5 cycles.
- Read and write both high, SB, addr 0x1, wdata 0x5A -> be = 0010, wdata = 0x5A5A5A5A, we = 1.
- Reset asserted mid-REQ, then a stray ack -> o_bus_req drops without waiting for a clock; stray ack produces no DONE and no o_rdata change.
- LSU_MISALIGN_CHECK_EN defined, LW addr 0x102 -> no o_bus_req, o_misaligned pulses 1 cycle, o_stall 1 cycle.
- LSU_MISALIGN_CHECK_EN undefined, LW addr 0x102 -> bus addr 0x100, normal completion.
